// File: rtl/fe_pow2k_mul.sv
// fe_pow2k_mul: requester-side sequencer for the fe_mulx field multiplier.
// Computes res = a^(2^k) [* b] over GF(2^255-19) by issuing k back-to-back
// squarings followed by an optional multiply by b. All arithmetic happens in
// fe_mulx; this block only steers W-bit words between registers and the
// multiplier port, keeping operands stable while a multiply is outstanding.
module fe_pow2k_mul #(
  parameter int W  = 320,
  parameter int KW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [KW-1:0] k,
  input  logic          mul_en,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  res,
  output logic [W-1:0]  mul_op_a,
  output logic [W-1:0]  mul_op_b,
  output logic          mul_valid,
  input  logic [W-1:0]  mul_res,
  input  logic          mul_done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SQ_ISSUE  = 3'd1,
    SQ_WAIT   = 3'd2,
    MUL_ISSUE = 3'd3,
    MUL_WAIT  = 3'd4,
    FIN       = 3'd5
  } state_t;

  localparam logic [KW-1:0] CNT_ONE = KW'(1);

  state_t        state_reg, state_next;
  logic [W-1:0]  acc_reg, acc_next;
  logic [W-1:0]  b_reg, b_next;
  logic [KW-1:0] cnt_reg, cnt_next;
  logic          men_reg, men_next;
  logic [W-1:0]  res_reg, res_next;
  logic [W-1:0]  op_a_reg, op_a_next;
  logic [W-1:0]  op_b_reg, op_b_next;
  logic          mul_valid_reg, mul_valid_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  // State and datapath registers; every output is registered so it is glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      b_reg         <= '0;
      cnt_reg       <= '0;
      men_reg       <= 1'b0;
      res_reg       <= '0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      mul_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      b_reg         <= b_next;
      cnt_reg       <= cnt_next;
      men_reg       <= men_next;
      res_reg       <= res_next;
      op_a_reg      <= op_a_next;
      op_b_reg      <= op_b_next;
      mul_valid_reg <= mul_valid_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  // Next-state logic plus datapath moves; outputs are derived from the
  // next state so they line up with the state they belong to.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    b_next     = b_reg;
    cnt_next   = cnt_reg;
    men_next   = men_reg;
    res_next   = res_reg;

    unique case (state_reg)
      IDLE: begin
        if (valid) begin
          acc_next = a;
          b_next   = b;
          cnt_next = k;
          men_next = mul_en;
          if (k != '0) begin
            state_next = SQ_ISSUE;
          end else if (mul_en) begin
            state_next = MUL_ISSUE;
          end else begin
            // Zero multiplies: result is the base element itself.
            state_next = FIN;
            res_next   = a;
          end
        end
      end

      SQ_ISSUE: begin
        // A done pulse here cannot belong to this request; drop it.
        state_next = SQ_WAIT;
      end

      SQ_WAIT: begin
        if (mul_done) begin
          acc_next = mul_res;
          cnt_next = cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            if (men_reg) begin
              state_next = MUL_ISSUE;
            end else begin
              state_next = FIN;
              res_next   = mul_res;
            end
          end else begin
            state_next = SQ_ISSUE;
          end
        end
      end

      MUL_ISSUE: begin
        state_next = MUL_WAIT;
      end

      MUL_WAIT: begin
        if (mul_done) begin
          acc_next   = mul_res;
          res_next   = mul_res;
          state_next = FIN;
        end
      end

      FIN: begin
        // valid here is ignored; a new request is taken once back in IDLE.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand and handshake registers: operands load only when entering an
  // issue state, so they stay frozen for the whole wait.
  always_comb begin
    op_a_next      = op_a_reg;
    op_b_next      = op_b_reg;
    mul_valid_next = 1'b0;
    busy_next      = (state_next != IDLE);
    done_next      = (state_next == FIN);

    if (state_next == SQ_ISSUE) begin
      mul_valid_next = 1'b1;
      op_a_next      = acc_next;
      op_b_next      = acc_next;
    end else if (state_next == MUL_ISSUE) begin
      mul_valid_next = 1'b1;
      op_a_next      = acc_next;
      op_b_next      = b_next;
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign res       = res_reg;
  assign mul_op_a  = op_a_reg;
  assign mul_op_b  = op_b_reg;
  assign mul_valid = mul_valid_reg;

endmodule

// File: tb/tb_fe_pow2k_mul.sv
// Testbench for fe_pow2k_mul with a stub multiplier (limb0 product, latency 5).
module tb_fe_pow2k_mul;

  localparam int W  = 320;
  localparam int KW = 8;

  logic          clk;
  logic          rst;
  logic          valid;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [KW-1:0] k;
  logic          mul_en;
  logic          busy;
  logic          done;
  logic [W-1:0]  res;
  logic [W-1:0]  mul_op_a;
  logic [W-1:0]  mul_op_b;
  logic          mul_valid;
  logic [W-1:0]  mul_res;
  logic          mul_done;

  logic          stub_rst;
  logic [4:0]    stub_pipe;
  logic [W-1:0]  stub_res;

  int checks = 0;
  int errors = 0;

  fe_pow2k_mul #(.W(W), .KW(KW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .a         (a),
    .b         (b),
    .k         (k),
    .mul_en    (mul_en),
    .busy      (busy),
    .done      (done),
    .res       (res),
    .mul_op_a  (mul_op_a),
    .mul_op_b  (mul_op_b),
    .mul_valid (mul_valid),
    .mul_res   (mul_res),
    .mul_done  (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub multiplier: done pulse 5 cycles after the mul_valid cycle
  always @(posedge clk) begin
    if (stub_rst) begin
      stub_pipe <= '0;
      stub_res  <= '0;
    end else begin
      stub_pipe <= {stub_pipe[3:0], mul_valid};
      if (mul_valid) stub_res <= {{(W-32){1'b0}}, mul_op_a[31:0] * mul_op_b[31:0]};
    end
  end
  assign mul_res  = stub_res;
  assign mul_done = stub_pipe[4];

  // Drives one request in cycle 0 and observes until done (bounded)
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [KW-1:0] tk, input logic tmen, input bit extra,
                        output int dcyc, output int pulses, output int busy_cnt,
                        output logic [W-1:0] rres, output int hold_err,
                        output logic [W-1:0] first_a, output logic [W-1:0] first_b);
    int cyc;
    bit outstanding;
    logic [W-1:0] cap_a, cap_b;
    @(negedge clk);
    valid = 1'b1; a = ta; b = tb_v; k = tk; mul_en = tmen;
    dcyc = -1; pulses = 0; busy_cnt = 0; hold_err = 0; rres = '0;
    first_a = '0; first_b = '0; cyc = 0; outstanding = 1'b0;
    cap_a = '0; cap_b = '0;
    while (cyc < 300 && dcyc < 0) begin
      @(negedge clk);
      cyc++;
      valid = extra && (cyc >= 2) && (cyc <= 10);
      if (valid) a = 320'd7;
      if (mul_valid) begin
        if (outstanding) hold_err++;
        if (pulses == 0) begin first_a = mul_op_a; first_b = mul_op_b; end
        pulses++;
        outstanding = 1'b1;
        cap_a = mul_op_a;
        cap_b = mul_op_b;
      end else if (outstanding) begin
        if (mul_op_a !== cap_a || mul_op_b !== cap_b) hold_err++;
      end
      if (mul_done) outstanding = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin dcyc = cyc; rres = res; end
    end
    valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mul_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b done=%b mul_valid=%b required 0 0 0", busy, done, mul_valid);
    end
    checks++;
    if (res !== '0 || mul_op_a !== '0 || mul_op_b !== '0) begin
      errors++;
      $display("FAIL reset_data res=%0h op_a=%0h op_b=%0h required 0", res, mul_op_a, mul_op_b);
    end
    $display("test_reset done");
  endtask

  task automatic test_squarings();
    int dcyc, pulses, bcnt, herr;
    logic [W-1:0] r, fa, fb;
    run_op(320'd2, 320'd0, 8'd3, 1'b0, 1'b0, dcyc, pulses, bcnt, r, herr, fa, fb);
    checks++;
    if (r !== 320'h100) begin errors++; $display("FAIL sq_res got %0h required 100", r); end
    checks++;
    if (pulses !== 3) begin errors++; $display("FAIL sq_pulses got %0d required 3", pulses); end
    checks++;
    if (dcyc !== 19) begin errors++; $display("FAIL sq_done_cycle got %0d required 19", dcyc); end
    checks++;
    if (bcnt !== 19) begin errors++; $display("FAIL sq_busy_cycles got %0d required 19", bcnt); end
    checks++;
    if (fa !== 320'd2 || fb !== 320'd2) begin
      errors++; $display("FAIL sq_first_ops got %0h,%0h required 2,2", fa, fb);
    end
    checks++;
    if (herr !== 0) begin errors++; $display("FAIL sq_hold got %0d required 0", herr); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || res !== 320'h100) begin
      errors++; $display("FAIL sq_after busy=%b done=%b res=%0h required 0 0 100", busy, done, res);
    end
    $display("test_squarings a=2 k=3 res=%0h done_cycle=%0d pulses=%0d", r, dcyc, pulses);
  endtask

  task automatic test_mul_only();
    int dcyc, pulses, bcnt, herr;
    logic [W-1:0] r, fa, fb;
    run_op(320'd3, 320'd5, 8'd0, 1'b1, 1'b0, dcyc, pulses, bcnt, r, herr, fa, fb);
    checks++;
    if (r !== 320'd15) begin errors++; $display("FAIL mul_res got %0h required f", r); end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL mul_pulses got %0d required 1", pulses); end
    checks++;
    if (fa !== 320'd3 || fb !== 320'd5 || herr !== 0) begin
      errors++; $display("FAIL mul_ops got %0h,%0h hold_err=%0d required 3,5,0", fa, fb, herr);
    end
    checks++;
    if (dcyc !== 7) begin errors++; $display("FAIL mul_done_cycle got %0d required 7", dcyc); end
    $display("test_mul_only a=3 b=5 res=%0h done_cycle=%0d", r, dcyc);
  endtask

  task automatic test_passthrough();
    int dcyc, pulses, bcnt, herr;
    logic [W-1:0] r, fa, fb;
    run_op(320'h1234, 320'd9, 8'd0, 1'b0, 1'b0, dcyc, pulses, bcnt, r, herr, fa, fb);
    checks++;
    if (r !== 320'h1234) begin errors++; $display("FAIL pass_res got %0h required 1234", r); end
    checks++;
    if (dcyc !== 1) begin errors++; $display("FAIL pass_done_cycle got %0d required 1", dcyc); end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL pass_pulses got %0d required 0", pulses); end
    checks++;
    if (bcnt !== 1) begin errors++; $display("FAIL pass_busy_cycles got %0d required 1", bcnt); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL pass_busy_c2 got %b required 0", busy); end
    $display("test_passthrough a=1234 res=%0h done_cycle=%0d", r, dcyc);
  endtask

  task automatic test_back_to_back();
    int dcyc, pulses, bcnt, herr;
    logic [W-1:0] r, fa, fb;
    run_op(320'd2, 320'd3, 8'd2, 1'b1, 1'b1, dcyc, pulses, bcnt, r, herr, fa, fb);
    checks++;
    if (r !== 320'd48) begin errors++; $display("FAIL b2b_res got %0h required 30", r); end
    checks++;
    if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses got %0d required 3", pulses); end
    checks++;
    if (dcyc !== 19 || herr !== 0) begin
      errors++; $display("FAIL b2b_timing done_cycle=%0d hold_err=%0d required 19,0", dcyc, herr);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res !== 320'd48) begin
      errors++; $display("FAIL b2b_after busy=%b res=%0h required 0 30", busy, res);
    end
    $display("test_back_to_back a=2 b=3 k=2 res=%0h done_cycle=%0d", r, dcyc);
  endtask

  task automatic test_abort();
    int pulses, cyc, stray;
    int dcyc, p2, bcnt, herr;
    logic [W-1:0] r, fa, fb;
    @(negedge clk);
    valid = 1'b1; a = 320'd2; b = 320'd0; k = 8'd3; mul_en = 1'b0;
    pulses = 0; cyc = 0;
    while (pulses < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      valid = 1'b0;
      if (mul_valid) pulses++;
    end
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL abort_reach got %0d pulses required 2", pulses); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mul_valid !== 1'b0 || res !== '0 ||
        mul_op_a !== '0 || mul_op_b !== '0) begin
      errors++;
      $display("FAIL abort_outputs busy=%b done=%b mv=%b res=%0h op_a=%0h op_b=%0h required all 0",
               busy, done, mul_valid, res, mul_op_a, mul_op_b);
    end
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || done || mul_valid) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL abort_late_done got %0d active cycles required 0", stray); end
    run_op(320'd2, 320'd0, 8'd3, 1'b0, 1'b0, dcyc, p2, bcnt, r, herr, fa, fb);
    checks++;
    if (r !== 320'h100 || dcyc !== 19 || p2 !== 3) begin
      errors++; $display("FAIL abort_rerun res=%0h done_cycle=%0d pulses=%0d required 100,19,3", r, dcyc, p2);
    end
    $display("test_abort rerun res=%0h done_cycle=%0d", r, dcyc);
  endtask

  initial begin
    rst = 1'b1; stub_rst = 1'b1; valid = 1'b0;
    a = '0; b = '0; k = '0; mul_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; stub_rst = 1'b0;
    test_reset();
    test_squarings();
    test_mul_only();
    test_passthrough();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
